// File: rtl/prog_clk_divider.sv
// Per-channel programmable divider: registered tick and square wave at clk/DIV, 1-cycle output latency.
// No backpressure; new divisors on running channels are held in a shadow until the period boundary.
module prog_clk_divider #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 26,
    parameter int DEFAULT_DIV = 2048
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [CHANNELS-1:0]                              en,
    input  logic                                             load,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
    input  logic [DIV_W-1:0]                                 div_in,
    output logic                                             load_err,
    output logic [CHANNELS-1:0]                              pending,
    output logic [CHANNELS-1:0]                              tick,
    output logic [CHANNELS-1:0]                              clk_out
);

    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    logic [DIV_W-1:0]    cnt_q     [CHANNELS];
    logic [DIV_W-1:0]    cnt_d     [CHANNELS];
    logic [DIV_W-1:0]    act_div_q [CHANNELS];
    logic [DIV_W-1:0]    act_div_d [CHANNELS];
    logic [DIV_W-1:0]    sh_div_q  [CHANNELS];
    logic [DIV_W-1:0]    sh_div_d  [CHANNELS];
    logic [CHANNELS-1:0] state_q, state_d;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] clk_out_q, clk_out_d;
    logic                load_err_q, load_err_d;

    logic [CHANNELS-1:0] ch_hit;
    logic [CHANNELS-1:0] run_now;
    logic [CHANNELS-1:0] wrap;
    logic [CHANNELS-1:0] ld;
    logic                load_ok;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_hit[i] = (ch_sel == CH_W'(i));
        end
        load_ok    = load && (|ch_hit) && (div_in >= DIV_MIN);
        load_err_d = load && !load_ok;
        for (int i = 0; i < CHANNELS; i++) begin
            // A channel whose enable drops this cycle counts as idle for loads.
            run_now[i] = (state_q[i] == ST_RUN) && en[i];
            wrap[i]    = run_now[i] && (cnt_q[i] == act_div_q[i] - ONE);
            ld[i]      = load_ok && ch_hit[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]     = cnt_q[i];
            act_div_d[i] = act_div_q[i];
            sh_div_d[i]  = sh_div_q[i];
            pend_d[i]    = pend_q[i];
            state_d[i]   = en[i] ? ST_RUN : ST_IDLE;
            tick_d[i]    = 1'b0;

            if (!run_now[i]) begin
                // Period aborted or not yet started: any shadow divisor is at its boundary now.
                cnt_d[i] = '0;
                if (pend_q[i]) begin
                    act_div_d[i] = sh_div_q[i];
                    pend_d[i]    = 1'b0;
                end
                if (ld[i]) begin
                    act_div_d[i] = div_in;
                end
            end else if (wrap[i]) begin
                cnt_d[i]  = '0;
                tick_d[i] = 1'b1;
                pend_d[i] = 1'b0;
                if (ld[i]) begin
                    act_div_d[i] = div_in;
                end else if (pend_q[i]) begin
                    act_div_d[i] = sh_div_q[i];
                end
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
                if (ld[i]) begin
                    sh_div_d[i] = div_in;
                    pend_d[i]   = 1'b1;
                end
            end

            // Square wave follows the next count so its rising edge lines up with tick.
            clk_out_d[i] = en[i] && (cnt_d[i] < (act_div_d[i] >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]     <= '0;
                act_div_q[i] <= DIV_RST;
                sh_div_q[i]  <= DIV_RST;
            end
            state_q    <= {CHANNELS{ST_IDLE}};
            pend_q     <= '0;
            tick_q     <= '0;
            clk_out_q  <= '0;
            load_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]     <= cnt_d[i];
                act_div_q[i] <= act_div_d[i];
                sh_div_q[i]  <= sh_div_d[i];
            end
            state_q    <= state_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            clk_out_q  <= clk_out_d;
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
    assign pending  = pend_q;
    assign tick     = tick_q;
    assign clk_out  = clk_out_q;

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider with three channels so an out-of-range ch_sel exists.
module tb_prog_clk_divider;

    localparam int CH = 3;
    localparam int DW = 26;
    localparam int DD = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] en;
    logic          load;
    logic [1:0]    ch_sel;
    logic [DW-1:0] div_in;
    logic          load_err;
    logic [CH-1:0] pending;
    logic [CH-1:0] tick;
    logic [CH-1:0] clk_out;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    prog_clk_divider #(
        .CHANNELS    (CH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .load     (load),
        .ch_sel   (ch_sel),
        .div_in   (div_in),
        .load_err (load_err),
        .pending  (pending),
        .tick     (tick),
        .clk_out  (clk_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input int ch, input int d);
        ch_sel = 2'(ch);
        div_in = DW'(d);
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    // Cycles until tick[ch] is observed, capped at budget.
    task automatic wait_tick(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < budget);
    endtask

    // Starting on a tick sample, counts high/low cycles of clk_out until the next tick.
    task automatic measure(input int ch, output int hi, output int lo);
        int guard;
        hi = 0;
        lo = 0;
        guard = 0;
        do begin
            if (clk_out[ch]) hi++;
            else lo++;
            step();
            guard++;
        end while (!tick[ch] && guard < 5000);
    endtask

    initial begin
        int n, hi, lo;
        reset  = 1'b1;
        en     = '0;
        load   = 1'b0;
        ch_sel = '0;
        div_in = '0;
        step();
        step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        reset = 1'b0;

        // Default divisor on ch0
        en = 3'b001;
        step();
        chk("t1_clk_out_start", 32'(clk_out[0]), 32'd1);
        wait_tick(0, DD + 50, n);
        chk("t1_first_tick", 32'(n), 32'(DD));
        chk("t1_clk_out_at_tick", 32'(clk_out[0]), 32'd1);
        measure(0, hi, lo);
        chk("t1_high", 32'(hi), 32'd1024);
        chk("t1_low", 32'(lo), 32'd1024);

        // Idle load on ch1 takes effect immediately
        do_load(1, 5);
        chk("t2_pending_idle", 32'(pending[1]), 32'd0);
        chk("t2_no_err", 32'(load_err), 32'd0);
        en = 3'b011;
        step();
        chk("t2_clk_out_start", 32'(clk_out[1]), 32'd1);
        wait_tick(1, 50, n);
        chk("t2_first_tick", 32'(n), 32'd5);
        measure(1, hi, lo);
        chk("t2_high", 32'(hi), 32'd2);
        chk("t2_low", 32'(lo), 32'd3);

        // ch0 at D=10, reload 4 mid-period
        en = 3'b010;
        step();
        chk("t3_drop_tick", 32'(tick[0]), 32'd0);
        chk("t3_drop_clk_out", 32'(clk_out[0]), 32'd0);
        do_load(0, 10);
        chk("t3_pending_idle", 32'(pending[0]), 32'd0);
        en = 3'b011;
        step();
        step();
        step();
        step();
        do_load(0, 4);
        chk("t3_pending_set", 32'(pending[0]), 32'd1);
        wait_tick(0, 50, n);
        chk("t3_finish_old", 32'(n), 32'd6);
        chk("t3_pending_clr", 32'(pending[0]), 32'd0);
        measure(0, hi, lo);
        chk("t3_high", 32'(hi), 32'd2);
        chk("t3_low", 32'(lo), 32'd2);

        // Load on the wrap cycle, then two loads while pending
        step();
        step();
        step();
        do_load(0, 6);
        chk("t4_wrap_tick", 32'(tick[0]), 32'd1);
        chk("t4_wrap_pending", 32'(pending[0]), 32'd0);
        chk("t4_wrap_clk_out", 32'(clk_out[0]), 32'd1);
        do_load(0, 8);
        chk("t4_pend_a", 32'(pending[0]), 32'd1);
        do_load(0, 7);
        chk("t4_pend_b", 32'(pending[0]), 32'd1);
        wait_tick(0, 50, n);
        chk("t4_period6_rest", 32'(n), 32'd4);
        chk("t4_pending_clr", 32'(pending[0]), 32'd0);
        measure(0, hi, lo);
        chk("t4_high", 32'(hi), 32'd3);
        chk("t4_low", 32'(lo), 32'd4);

        // Rejected loads
        do_load(1, 1);
        chk("t5_err_div1", 32'(load_err), 32'd1);
        step();
        chk("t5_err_clear", 32'(load_err), 32'd0);
        do_load(3, 9);
        chk("t5_err_chsel", 32'(load_err), 32'd1);
        do_load(0, 0);
        chk("t5_err_div0", 32'(load_err), 32'd1);
        chk("t5_no_pending", 32'(pending), 32'd0);
        wait_tick(1, 10, n);
        chk("t5_ch1_tick", 32'(tick[1]), 32'd1);
        measure(1, hi, lo);
        chk("t5_ch1_high", 32'(hi), 32'd2);
        chk("t5_ch1_low", 32'(lo), 32'd3);
        wait_tick(0, 10, n);
        measure(0, hi, lo);
        chk("t5_ch0_period", 32'(hi + lo), 32'd7);

        // en dropped mid-period with a pending divisor
        wait_tick(1, 10, n);
        do_load(1, 4);
        chk("t6_pend_ch1", 32'(pending[1]), 32'd1);
        en = 3'b001;
        step();
        chk("t6_drop_tick", 32'(tick[1]), 32'd0);
        chk("t6_drop_clk_out", 32'(clk_out[1]), 32'd0);
        chk("t6_drop_pending", 32'(pending[1]), 32'd0);

        // Load coinciding with en falling is an immediate load
        en = 3'b011;
        step();
        step();
        en = 3'b001;
        do_load(1, 3);
        chk("t6_fall_load_pend", 32'(pending[1]), 32'd0);
        chk("t6_fall_load_clk", 32'(clk_out[1]), 32'd0);
        en = 3'b011;
        step();
        wait_tick(1, 20, n);
        chk("t6_fall_load_period", 32'(n), 32'd3);

        // Reset mid-period with pending set
        wait_tick(0, 20, n);
        do_load(0, 9);
        chk("t6_pend_ch0", 32'(pending[0]), 32'd1);
        reset = 1'b1;
        step();
        chk("t6_rst_tick", 32'(tick), 32'd0);
        chk("t6_rst_clk_out", 32'(clk_out), 32'd0);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_load_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        step();
        chk("t6_restart_clk_out", 32'(clk_out), 32'd3);
        wait_tick(0, DD + 50, n);
        chk("t6_default_div", 32'(n), 32'(DD));
        chk("t6_ch1_default", 32'(tick[1]), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
